// File: rtl/seq_checker_pkg.sv
// +----------------------------------------------------------------------------+
// | seq_checker_pkg : shared state encoding and default sizes for seq_checker  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package seq_checker_pkg;

  localparam int unsigned c_width_default  = 3;
  localparam int unsigned c_err_w_default  = 8;
  localparam int unsigned c_wrap_w_default = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_checker_sat_inc.sv
// +----------------------------------------------------------------------------+
// | sat_inc : counter that increments on enable and sticks at all-ones         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sat_inc #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  // clear wins over inc so a same-cycle clear always lands at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/seq_checker.sv
// +----------------------------------------------------------------------------+
// | seq_checker : tracks an upstream wrapping counter and flags sequence and   |
// | terminal-count violations. Define SEQ_CHECKER_RESYNC_EN to allow FAULT to  |
// | re-acquire on the next valid sample instead of waiting for clear/reset.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module seq_checker
  import seq_checker_pkg::*;
#(
  parameter int unsigned WIDTH  = c_width_default,
  parameter int unsigned ERR_W  = c_err_w_default,
  parameter int unsigned WRAP_W = c_wrap_w_default
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_cnt,
  input  logic              in_done,
  output logic              locked,
  output logic              err,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [WIDTH-1:0]  expected
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_expected;
  logic [WIDTH-1:0] w_expected_nxt;
  logic             r_err;
  logic             w_err_nxt;
  logic             r_locked;
  logic             w_wrap_inc;
  logic             w_all_ones;
  logic             w_bad;
  logic             w_acquire;

  assign w_all_ones = (in_cnt == '1);
  assign w_bad      = (in_cnt != r_expected) || (in_done != w_all_ones);

`ifdef SEQ_CHECKER_RESYNC_EN
  assign w_acquire = in_valid && ((r_state == IDLE) || (r_state == FAULT));
`else
  assign w_acquire = in_valid && (r_state == IDLE);
`endif

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_expected <= '0;
      r_err      <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_expected <= w_expected_nxt;
      r_err      <= w_err_nxt;
      r_locked   <= (w_state_nxt == TRACK);
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = IDLE;
    end else if (in_valid) begin
      case (r_state)
        IDLE:    w_state_nxt = TRACK;
        TRACK:   w_state_nxt = w_bad ? FAULT : TRACK;
`ifdef SEQ_CHECKER_RESYNC_EN
        FAULT:   w_state_nxt = TRACK;
`else
        FAULT:   w_state_nxt = FAULT;
`endif
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Output / counter-enable logic
  always_comb begin
    w_expected_nxt = r_expected;
    w_err_nxt      = 1'b0;
    w_wrap_inc     = 1'b0;
    if (clear) begin
      w_expected_nxt = '0;
    end else if (w_acquire) begin
      w_expected_nxt = in_cnt + 1'b1;
    end else if (in_valid && (r_state == TRACK)) begin
      if (w_bad) begin
        w_err_nxt = 1'b1;
      end else begin
        w_expected_nxt = in_cnt + 1'b1;
        w_wrap_inc     = w_all_ones;
      end
    end
  end

  // err_cnt steps on the same condition that raises the err pulse
  sat_inc #(.WIDTH(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .inc   (w_err_nxt),
    .count (err_cnt)
  );

  sat_inc #(.WIDTH(WRAP_W)) u_wrap_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .inc   (w_wrap_inc),
    .count (wrap_cnt)
  );

  assign locked   = r_locked;
  assign err      = r_err;
  assign expected = r_expected;

endmodule

`default_nettype wire
